led_scan: RTL and testbench
===========================

LED_SCAN -- requirements
Module: led_scan

Interface
REQ-001 SHALL have parameter BLANK_CYCLES, default 16, meaning all-rows-off guard interval at the start of each row dwell.
REQ-002 SHALL have parameter ON_UNIT, default 128, meaning cycles per brightness step; row dwell DWELL = BLANK_CYCLES + 16*ON_UNIT (2064 by default).
REQ-003 SHALL have port clk, input, 1, single system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port addr, input, [0:11], memory address register for the address lamp row.
REQ-006 SHALL have port ema, input, [0:2], extended memory address lamps.
REQ-007 SHALL have port dout, input, [0:11], selected display-mux data word.
REQ-008 SHALL have port run_led, input, 1, run lamp.
REQ-009 SHALL have port brightness, input, [0:3], lamp intensity 0 (dark) to 15.
REQ-010 SHALL have port lamp_test, input, 1, force all lamps on at full intensity.
REQ-011 SHALL have port row_n, output, [0:2], active-low row enables; row 0 address, row 1 data, row 2 status.
REQ-012 SHALL have port col, output, [0:11], active-high column drives.

Function
REQ-013 SHALL scan rows 0, 1, 2, 0, ... with each row occupying exactly DWELL cycles, counted by a dwell counter cnt running 0..DWELL-1.
REQ-014 SHALL use a three-state machine per row: BLANK (cnt 0..BLANK_CYCLES-1), ON (next bri*ON_UNIT cycles), OFF (remainder to DWELL-1); at cnt = DWELL-1 it SHALL return to BLANK and advance row, wrapping 2 to 0.
REQ-015 SHALL sample brightness into bri on the cycle cnt = 0 of every row; bri changes mid-row SHALL NOT take effect until the next row.
REQ-016 SHALL skip ON when bri = 0, going BLANK to OFF; with bri = 15, OFF SHALL last exactly ON_UNIT cycles.
REQ-017 SHALL capture a frame snapshot of addr, ema, dout, run_led and lamp_test on the edge where row = 0 and cnt = 0; rows SHALL display only snapshot values, so one frame is never torn.
REQ-018 SHALL form row data as: row 0 = addr[0:11]; row 1 = dout[0:11]; row 2 = {ema[0:2], run_led, 8'b0}.
REQ-019 SHALL, when snapshot lamp_test = 1, drive col = 12'hFFF for all rows and use bri = 15 for the whole frame, ignoring brightness.
REQ-020 SHALL register row_n and col, each reflecting machine state of the previous cycle, so the output latency is 1 cycle.
REQ-021 SHALL hold row_n = 3'b111 and col = 0 during BLANK and OFF.
REQ-022 SHALL, during ON, drive exactly one row_n bit low and col with that row's data.
REQ-023 SHALL keep at most one row_n bit low in any cycle, including across reset.

Reset
REQ-024 SHALL, while reset is high, force row_n = 3'b111, col = 0, state BLANK, row = 0, cnt = 0, bri = 0, and snapshot = 0, asynchronously.
REQ-025 SHALL take its first snapshot on the first rising edge after reset deasserts.
REQ-026 SHALL, on reset mid-ON, extinguish all rows within the reset assertion with no residual pulse afterward.

Structure
REQ-027 SHALL place the BLANK/ON/OFF state encodings and the default BLANK_CYCLES/ON_UNIT constants in the shared front-panel parameters file.
REQ-028 SHALL be a single module with no sub-modules; a separate timing sub-module, if factored out, SHALL be named scan_timer and contain only cnt and the state machine.
REQ-029 SHALL fit in 120-400 lines of RTL.

Verification
REQ-030 SHALL verify brightness = 8, addr = 12'o1234, dout = 12'o7070: row_n[0] is low for 1024 cycles per dwell, col = 12'o1234 while low, and the row period is 2064 cycles.
REQ-031 SHALL verify brightness = 0: row_n stays 3'b111 and col stays 0 for 3 full frames.
REQ-032 SHALL verify that changing dout from 12'o0000 to 12'o7777 during row 1 ON leaves col = 12'o0000 until the next frame's row 1.
REQ-033 SHALL verify lamp_test = 1 with brightness = 2: col = 12'hFFF on all rows, each row low for 1920 cycles, taking effect on the next frame.
REQ-034 SHALL verify that reset asserted mid-ON of row 2 immediately yields row_n = 3'b111 and col = 0, and that after release row 0 is scanned first.
REQ-035 SHALL verify with ema = 3'b101 and run_led = 1 that row 2 col = 12'b1011_0000_0000.

Source files
------------

// File: rtl/led_scan_pkg.sv
// Shared front-panel parameters for the lamp scanner.
// Holds the per-row dwell state encodings and the default timing constants.
package led_scan_pkg;

  // Row dwell phases: guard interval, lamps lit, lamps dark for the remainder.
  typedef enum logic [1:0] {
    StBlank = 2'd0,
    StOn    = 2'd1,
    StOff   = 2'd2
  } scan_state_e;

  localparam int unsigned DefBlankCycles = 16;
  localparam int unsigned DefOnUnit      = 128;
  localparam int unsigned NumRows        = 3;

endpackage

// File: rtl/led_scan.sv
// Front-panel lamp matrix scanner.
// Scans three lamp rows (0 address, 1 data, 2 status) with a PWM-style dwell per row:
// a BLANK guard interval, an ON phase of bri*ON_UNIT cycles, then OFF to the end of the dwell.
// Ports:
//   clk, reset     - system clock, asynchronous active-high reset
//   addr, dout     - 12-bit address / data words shown on rows 0 / 1
//   ema, run_led   - extended address and run lamps shown on row 2
//   brightness     - lamp intensity 0..15, sampled at the start of each row
//   lamp_test      - all lamps on at full intensity (takes effect per frame)
//   row_n          - active-low row enables, registered
//   col            - active-high column drives, registered
module led_scan
  import led_scan_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = DefBlankCycles,
  parameter int unsigned ON_UNIT      = DefOnUnit
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:11] addr,
  input  logic [0:2]  ema,
  input  logic [0:11] dout,
  input  logic        run_led,
  input  logic [0:3]  brightness,
  input  logic        lamp_test,
  output logic [0:2]  row_n,
  output logic [0:11] col
);

  localparam int unsigned DWELL = BLANK_CYCLES + 16 * ON_UNIT;
  localparam int unsigned CW    = $clog2(DWELL);

  scan_state_e     r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_row;
  logic [0:3]      r_bri;

  // Frame snapshot; every row of a frame displays only these values.
  logic [0:11]     r_snap_addr;
  logic [0:2]      r_snap_ema;
  logic [0:11]     r_snap_dout;
  logic            r_snap_run;
  logic            r_snap_lt;

  logic            w_last;
  logic            w_frame_start;
  logic            w_lt_eff;
  logic [0:3]      w_bri_smp;
  logic [0:3]      w_bri;
  logic            w_blank_last;
  logic [CW-1:0]   w_on_last_cnt;
  logic [0:2]      w_row_sel_n;
  logic [0:11]     w_row_data;

  assign w_last        = (r_cnt == CW'(DWELL - 1));
  assign w_frame_start = (r_row == 2'd0) && (r_cnt == '0);

  // At frame start the snapshot is being loaded on this very edge, so row 0 must
  // see the incoming lamp_test rather than the previous frame's value.
  assign w_lt_eff  = w_frame_start ? lamp_test : r_snap_lt;
  assign w_bri_smp = w_lt_eff ? 4'hF : brightness;
  // Bypass keeps the BLANK exit decision correct even for a one-cycle guard.
  assign w_bri     = (r_cnt == '0) ? w_bri_smp : r_bri;

  assign w_blank_last  = (r_cnt == CW'(BLANK_CYCLES - 1));
  assign w_on_last_cnt = CW'(BLANK_CYCLES + ON_UNIT * {28'd0, r_bri} - 32'd1);

  always_comb begin
    w_row_sel_n = 3'b111;
    w_row_data  = 12'h000;
    unique case (r_row)
      2'd0: begin
        w_row_sel_n = 3'b011;
        w_row_data  = r_snap_addr;
      end
      2'd1: begin
        w_row_sel_n = 3'b101;
        w_row_data  = r_snap_dout;
      end
      2'd2: begin
        w_row_sel_n = 3'b110;
        w_row_data  = {r_snap_ema, r_snap_run, 8'b0};
      end
      default: begin
        w_row_sel_n = 3'b111;
        w_row_data  = 12'h000;
      end
    endcase
    if (r_snap_lt) begin
      w_row_data = 12'hFFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StBlank;
      r_cnt       <= '0;
      r_row       <= 2'd0;
      r_bri       <= 4'h0;
      r_snap_addr <= 12'h000;
      r_snap_ema  <= 3'b000;
      r_snap_dout <= 12'h000;
      r_snap_run  <= 1'b0;
      r_snap_lt   <= 1'b0;
      row_n       <= 3'b111;
      col         <= 12'h000;
    end else begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);

      if (r_cnt == '0) begin
        r_bri <= w_bri_smp;
      end

      if (w_frame_start) begin
        r_snap_addr <= addr;
        r_snap_ema  <= ema;
        r_snap_dout <= dout;
        r_snap_run  <= run_led;
        r_snap_lt   <= lamp_test;
      end

      unique case (r_state)
        StBlank: begin
          if (w_blank_last) begin
            r_state <= (w_bri != 4'h0) ? StOn : StOff;
          end
        end
        StOn: begin
          if (r_cnt == w_on_last_cnt) begin
            r_state <= StOff;
          end
        end
        StOff: begin
          if (w_last) begin
            r_state <= StBlank;
            r_row   <= (r_row == 2'(NumRows - 1)) ? 2'd0 : r_row + 2'd1;
          end
        end
        default: r_state <= StBlank;
      endcase

      // Outputs lag the machine state by one cycle.
      row_n <= (r_state == StOn) ? w_row_sel_n : 3'b111;
      col   <= (r_state == StOn) ? w_row_data : 12'h000;
    end
  end

endmodule

// File: tb/tb_led_scan.sv
module tb_led_scan;

  localparam int Budget = 7000;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:11] addr;
  logic [0:2]  ema;
  logic [0:11] dout;
  logic        run_led;
  logic [0:3]  brightness;
  logic        lamp_test;
  logic [0:2]  row_n;
  logic [0:11] col;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  led_scan dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .ema        (ema),
    .dout       (dout),
    .run_led    (run_led),
    .brightness (brightness),
    .lamp_test  (lamp_test),
    .row_n      (row_n),
    .col        (col)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:2] sel(input int idx);
    logic [0:2] r;
    r = 3'b111;
    r[idx] = 1'b0;
    return r;
  endfunction

  // At most one row enabled in any cycle, reset included.
  always @(negedge clk) begin
    check("onehot", {31'd0, ($countones(~row_n) <= 1)}, 32'd1);
  end

  task automatic wait_fall(input int idx, output int t);
    int n;
    n = 0;
    while (row_n[idx] !== 1'b0 && n < Budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_row_low", {31'd0, row_n[idx]}, 32'd0);
    t = cyc;
  endtask

  task automatic meas_pulse(input int idx, input logic [0:11] exp_col, input string tag,
                            output int w);
    int bad;
    bad = 0;
    w = 0;
    while (row_n[idx] === 1'b0 && w < 4000) begin
      if (col !== exp_col || row_n !== sel(idx)) bad++;
      w++;
      @(negedge clk);
    end
    check({tag, "_col"}, bad, 0);
    check({tag, "_dark"}, {17'd0, row_n, col}, {17'd0, 3'b111, 12'h000});
  endtask

  initial begin
    int t0, t1, t2, tp, t_rel, w, n, bad;
    reset      = 1'b1;
    addr       = 12'o1234;
    dout       = 12'o7070;
    ema        = 3'b101;
    run_led    = 1'b1;
    brightness = 4'd8;
    lamp_test  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_row_n", row_n, 3'b111);
    check("rst_col", col, 12'h000);
    reset = 1'b0;
    t_rel = cyc;

    // Brightness 8: 1024-cycle pulses, 2064-cycle row period.
    wait_fall(0, t0);
    check("first_latency", t0 - t_rel, 17);
    check("first_row", row_n, 3'b011);
    meas_pulse(0, 12'o1234, "r0", w);
    check("r0_width", w, 1024);
    wait_fall(1, t1);
    check("period01", t1 - t0, 2064);
    meas_pulse(1, 12'o7070, "r1", w);
    check("r1_width", w, 1024);
    wait_fall(2, t2);
    check("period12", t2 - t1, 2064);
    meas_pulse(2, 12'b1011_0000_0000, "r2", w);
    check("r2_width", w, 1024);

    // Snapshot tearing and mid-row brightness change.
    dout = 12'o0000;
    tp = t0;
    wait_fall(0, t0);
    check("frame_period", t0 - tp, 6192);
    brightness = 4'd4;
    meas_pulse(0, 12'o1234, "r0_brichg", w);
    check("r0_brichg_width", w, 1024);
    wait_fall(1, t1);
    repeat (10) @(negedge clk);
    dout = 12'o7777;
    meas_pulse(1, 12'o0000, "r1_tear", w);
    check("r1_tear_width", w, 502);
    wait_fall(2, t2);
    meas_pulse(2, 12'b1011_0000_0000, "r2_b4", w);
    check("r2_b4_width", w, 512);
    wait_fall(0, t0);
    meas_pulse(0, 12'o1234, "r0_b4", w);
    check("r0_b4_width", w, 512);
    wait_fall(1, t1);
    meas_pulse(1, 12'o7777, "r1_new", w);
    check("r1_new_width", w, 512);

    // Brightness 0: dark for three full frames.
    wait_fall(2, t2);
    brightness = 4'd0;
    meas_pulse(2, 12'b1011_0000_0000, "r2_last", w);
    check("r2_last_width", w, 512);
    bad = 0;
    for (int i = 0; i < 3 * 6192 + 100; i++) begin
      if (row_n !== 3'b111 || col !== 12'h000) bad++;
      @(negedge clk);
    end
    check("dark_frames", bad, 0);

    // Lamp test with brightness 2, effective from the next frame.
    brightness = 4'd2;
    wait_fall(1, t1);
    lamp_test = 1'b1;
    meas_pulse(1, 12'o7777, "r1_lt_pre", w);
    check("r1_lt_pre_width", w, 256);
    wait_fall(2, t2);
    meas_pulse(2, 12'b1011_0000_0000, "r2_lt_pre", w);
    check("r2_lt_pre_width", w, 256);
    wait_fall(0, t0);
    meas_pulse(0, 12'hFFF, "r0_lt", w);
    check("r0_lt_width", w, 1920);
    wait_fall(1, t1);
    check("lt_period", t1 - t0, 2064);
    meas_pulse(1, 12'hFFF, "r1_lt", w);
    check("r1_lt_width", w, 1920);
    wait_fall(2, t2);
    meas_pulse(2, 12'hFFF, "r2_lt", w);
    check("r2_lt_width", w, 1920);
    lamp_test  = 1'b0;
    brightness = 4'd8;

    // Reset in the middle of row 2 ON.
    wait_fall(2, t2);
    repeat (100) @(negedge clk);
    check("r2_on_before_rst", row_n, 3'b110);
    reset = 1'b1;
    #1;
    check("rst_async_row_n", row_n, 3'b111);
    check("rst_async_col", col, 12'h000);
    repeat (5) @(negedge clk);
    check("rst_hold_row_n", row_n, 3'b111);
    reset = 1'b0;
    t_rel = cyc;
    n = 0;
    while (row_n === 3'b111 && n < Budget) begin
      @(negedge clk);
      n++;
    end
    check("post_rst_first_row", row_n, 3'b011);
    check("post_rst_latency", cyc - t_rel, 17);
    check("post_rst_col", col, 12'o1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
